// File: rtl/uc_collector.sv
// Per-engine unit-literal FIFOs with a round-robin selector feeding one registered
// output stage toward uc_arbiter; a conflict flush empties everything.
module uc_collector #(
   parameter int NUM_ENGINE = 4,
   parameter int LIT_IDX_MAX = 1024,
   parameter int DEPTH = 4,
   localparam int LW = $clog2(LIT_IDX_MAX) + 1,
   localparam int SW = $clog2(NUM_ENGINE)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [NUM_ENGINE-1:0] eng_push,
   input  logic signed [LW-1:0]  eng_lit [NUM_ENGINE],
   output logic [NUM_ENGINE-1:0] eng_full,
   input  logic [NUM_ENGINE-1:0] engmask,
   input  logic                  uca_rd,
   input  logic                  flush,
   output logic                  eng2uca_valid,
   output logic                  eng2uca_empty,
   output logic signed [LW-1:0]  eng2uca,
   output logic [SW-1:0]         eng_sel,
   output logic                  overflow
);

   localparam int PW = $clog2(DEPTH) + 1;
   localparam logic [PW-1:0] PTR_ONE = 1;

   typedef enum logic {EMPTY, HOLD} state_t;

   state_t state, next_state;

   logic signed [LW-1:0] mem [NUM_ENGINE][DEPTH];
   logic [PW-1:0] wr_ptr [NUM_ENGINE];
   logic [PW-1:0] rd_ptr [NUM_ENGINE];

   logic [NUM_ENGINE-1:0] full, empty, eligible, accept, drop, pop;
   logic [SW-1:0] rr_ptr, winner;
   logic [SW:0] cand;
   logic any_elig, load;

   // Extra pointer MSB separates the full case from the empty case.
   always_comb begin
      full = '0;
      empty = '0;
      accept = '0;
      drop = '0;
      for (int i = 0; i < NUM_ENGINE; i++) begin
         full[i] = (wr_ptr[i][PW-2:0] == rd_ptr[i][PW-2:0]) &&
                   (wr_ptr[i][PW-1] != rd_ptr[i][PW-1]);
         empty[i] = (wr_ptr[i] == rd_ptr[i]);
         accept[i] = eng_push[i] && !full[i] && (eng_lit[i] != '0) && !flush;
         drop[i] = eng_push[i] && full[i] && (eng_lit[i] != '0);
      end
   end

   assign eligible = engmask & ~empty;

   always_comb begin
      any_elig = 1'b0;
      winner = '0;
      cand = '0;
      for (int k = 1; k <= NUM_ENGINE; k++) begin
         cand = {1'b0, rr_ptr} + (SW+1)'(k);
         if (cand >= (SW+1)'(NUM_ENGINE))
            cand = cand - (SW+1)'(NUM_ENGINE);
         if (!any_elig && eligible[cand[SW-1:0]]) begin
            any_elig = 1'b1;
            winner = cand[SW-1:0];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst)
         state <= EMPTY;
      else if (flush)
         state <= EMPTY;
      else
         state <= next_state;
   end

   always_comb begin
      next_state = state;
      case (state)
         EMPTY:   next_state = any_elig ? HOLD : EMPTY;
         HOLD:    if (uca_rd) next_state = any_elig ? HOLD : EMPTY;
         default: next_state = EMPTY;
      endcase
   end

   always_comb begin
      load = 1'b0;
      case (state)
         EMPTY:   load = any_elig;
         HOLD:    load = uca_rd && any_elig;
         default: load = 1'b0;
      endcase
      load = load && !flush;
      pop = '0;
      for (int i = 0; i < NUM_ENGINE; i++)
         pop[i] = load && (winner == SW'(i));
   end

   assign eng2uca_valid = (state == HOLD);
   assign eng2uca_empty = ~eng2uca_valid;
   assign eng_full = full;

   always_ff @(posedge clk) begin
      for (int i = 0; i < NUM_ENGINE; i++)
         if (rst && accept[i])
            mem[i][wr_ptr[i][PW-2:0]] <= eng_lit[i];
   end

   // Fullness comes from start-of-cycle state, so a pop never rescues a push to a full FIFO.
   always_ff @(posedge clk) begin
      if (!rst || flush) begin
         for (int i = 0; i < NUM_ENGINE; i++) begin
            wr_ptr[i] <= '0;
            rd_ptr[i] <= '0;
         end
         rr_ptr <= SW'(NUM_ENGINE - 1);
         eng2uca <= '0;
         eng_sel <= '0;
         overflow <= 1'b0;
      end else begin
         for (int i = 0; i < NUM_ENGINE; i++) begin
            if (accept[i])
               wr_ptr[i] <= wr_ptr[i] + PTR_ONE;
            if (pop[i])
               rd_ptr[i] <= rd_ptr[i] + PTR_ONE;
         end
         if (|drop)
            overflow <= 1'b1;
         if (load) begin
            eng2uca <= mem[winner][rd_ptr[winner][PW-2:0]];
            eng_sel <= winner;
            rr_ptr <= winner;
         end
      end
   end

endmodule

// File: doc/uc_collector.md
# uc_collector

Per-engine unit-literal collection stage directly upstream of `uc_arbiter`. Each BCP engine pushes implied literals into its own small FIFO here. The block round-robins across the engines enabled by the arbiter's `engmask` and presents one literal at a time on the arbiter's `eng2uca*` inputs through a single registered output stage. It also drives the per-engine full flags and flushes everything on conflict.

## Interface
- `NUM_ENGINE`, default 4: number of BCP engines (≥2).
- `LIT_IDX_MAX`, default 1024: max literal index. Literal width `LW = $clog2(LIT_IDX_MAX)+1`, signed; 0 means "no literal".
- `DEPTH`, default 4: per-engine FIFO depth (power of 2, ≥2).

Ports:
- `clk` in 1: clock; all state updates on the rising edge.
- `rst` in 1: reset is synchronous and active-low; one clock.
- `eng_push` in NUM_ENGINE: per-engine push strobe.
- `eng_lit` in NUM_ENGINE×LW signed: per-engine literal, sampled when `eng_push[i]`.
- `eng_full` out NUM_ENGINE: FIFO i holds DEPTH entries (to engines and `uc_arbiter.eng2uca_full`).
- `engmask` in NUM_ENGINE: from `uc_arbiter`; only masked-in engines are eligible for selection.
- `uca_rd` in 1: arbiter consumes the presented literal.
- `flush` in 1: the arbiter's `conflict`; clears all buffered literals.
- `eng2uca_valid` out 1: output register holds a literal.
- `eng2uca_empty` out 1: always `~eng2uca_valid`.
- `eng2uca` out LW signed: presented literal.
- `eng_sel` out $clog2(NUM_ENGINE): source engine of the presented literal.
- `overflow` out 1: sticky; a push was dropped because its FIFO was full.

## Operation
- FIFOs:
  - Circular buffers, one per engine.
  - Read and write pointers are $clog2(DEPTH)+1 bits wide, so the extra bit distinguishes full from empty.
  - Full when the low bits are equal and the MSBs differ. Empty when the pointers are equal.
- Push acceptance:
  - Accepted iff `eng_push[i]` && !full(i) && `eng_lit[i]`!=0 && !`flush`.
  - `full(i)` is evaluated from the register state at the start of the cycle. A push to a full FIFO is dropped even if the same FIFO is popped that cycle, and `overflow` is set.
  - A zero literal is silently ignored and does not set `overflow`.
- Eligibility: engine i is eligible iff `engmask[i]` && FIFO i is non-empty.
- Round-robin:
  - `rr_ptr` resets to NUM_ENGINE-1.
  - Search order is `rr_ptr`+1, `rr_ptr`+2, … modulo NUM_ENGINE. The first eligible engine wins.
  - On each load of the output register, `rr_ptr` is set to the winner.
- Output FSM:
  - EMPTY:
    - If any engine is eligible: pop the winner's head into `eng2uca`, set `eng_sel` to the winner, go to HOLD.
    - Otherwise stay in EMPTY.
  - HOLD:
    - `eng2uca_valid`=1 and the output is stable.
    - If `uca_rd` and some engine is eligible: load the next winner in the same cycle and stay in HOLD (back-to-back, one literal per cycle).
    - If `uca_rd` and nothing is eligible: go to EMPTY.
    - If !`uca_rd`: hold.
- A literal already loaded into the output register stays presented even if `engmask` later drops its engine.
- `flush`:
  - Overrides everything else.
  - Next cycle: all pointers are equal (all FIFOs empty), FSM is EMPTY, `eng2uca`=0, `rr_ptr`=NUM_ENGINE-1.
  - `overflow` is cleared.
  - A push or `uca_rd` in the flush cycle is discarded.
- `uca_rd` while EMPTY is ignored.

## Timing
- Reset values:
  - `eng2uca_valid`=0, `eng2uca_empty`=1, `eng2uca`=0, `eng_sel`=0.
  - `eng_full`=0, `overflow`=0, `rr_ptr`=NUM_ENGINE-1, FSM=EMPTY.
  - Reset takes priority over `flush`.
- Latency, push to presentation: push at edge N (into an empty block) → output register loaded at edge N+1 → `eng2uca_valid`=1 from N+1.
- Throughput: one literal per cycle while `uca_rd` is held and eligible data exists.
- `eng_full` is registered-state derived. It rises the cycle after the DEPTH-th accepted push and falls the cycle after a pop.
- Simultaneous push and pop on a non-full FIFO: both take effect and the occupancy is unchanged.

## Test plan
- Reset then idle:
  - Stimulus: hold `rst`=0 for 2 cycles with `eng_push` asserted.
  - Required: `eng2uca_empty`=1, `eng_full`=0, `overflow`=0 after release, and no literals buffered.
- Single path:
  - Stimulus: `engmask`=4'b1111; engine 2 pushes 3 at edge N; `uca_rd`=1 once valid.
  - Required: `eng2uca`=3, `eng_sel`=2, valid at N+1; `eng2uca_empty`=1 at N+2.
- Round-robin:
  - Stimulus: engines 0..3 push 2, 4, 3, -2 in the same cycle; `uca_rd` held at 1.
  - Required: outputs 2, 4, 3, -2 on consecutive cycles with `eng_sel` 0, 1, 2, 3.
- Mask:
  - Stimulus: `engmask`=4'b0101, all four engines hold data.
  - Required: only engines 0 and 2 are presented, alternating. Engines 1 and 3 keep their data and are presented once the mask becomes 4'b1111.
- Full and overflow:
  - Stimulus: engine 1 pushes 10, 20, 30, 40, 50 with no reads.
  - Required: `eng_full[1]`=1 after the 4th push; 50 is dropped and `overflow`=1; the reads return 10, 20, 30, 40.
- Flush mid-stream:
  - Stimulus: 3 literals buffered and one presented, then `flush`=1 with a simultaneous push.
  - Required: next cycle `eng2uca_valid`=0, `overflow`=0, all FIFOs empty, and the pushed literal is never presented.
